floo_wide_endpoint: RTL

- Network-side endpoint for one wide link; the opposite end of a router wide port.
- Injection: packetizes a descriptor (dst_id, beat count) plus a payload beat stream into wide flits with header and last marker.
- Ejection: buffers incoming wide flits and delivers payload, src_id and last to the local consumer.
- Sits between a DMA-style engine and one router port; valid/ready on every interface.

---
 rtl/floo_wide_endpoint.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/floo_wide_endpoint.sv
// Wide-link network endpoint: packetizes descriptor + payload beats into flits
// and buffers ejected flits. Optional counters under FLOO_WIDE_ENDPOINT_STATS_EN.
module floo_wide_endpoint #(
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned LenWidth       = 8,
  parameter int unsigned EjectFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   src_id_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [IdWidth-1:0]   desc_dst_id_i,
  input  logic [LenWidth-1:0]  desc_len_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  input  logic [DataWidth-1:0] beat_data_i,
  output logic                 flit_valid_o,
  input  logic                 flit_ready_i,
  output logic [IdWidth-1:0]   flit_dst_id_o,
  output logic [IdWidth-1:0]   flit_src_id_o,
  output logic                 flit_last_o,
  output logic [DataWidth-1:0] flit_data_o,
  input  logic                 flit_valid_i,
  output logic                 flit_ready_o,
  input  logic [IdWidth-1:0]   flit_src_id_i,
  input  logic                 flit_last_i,
  input  logic [DataWidth-1:0] flit_data_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [IdWidth-1:0]   rx_src_id_o,
  output logic                 rx_last_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 busy_o
`ifdef FLOO_WIDE_ENDPOINT_STATS_EN
  ,
  output logic [31:0]          tx_flits_o,
  output logic [31:0]          rx_flits_o
`endif
);

  // ---------------- Injection ----------------
  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_reg, state_next;
  logic [LenWidth-1:0] cnt_reg, cnt_next;
  logic [IdWidth-1:0]  dst_reg, dst_next;
  logic                tx_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dst_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dst_reg   <= dst_next;
    end
  end

  // SEND is a combinational pass-through, so flit stability is inherited
  // from the upstream beat stream rather than from a skid register.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dst_next     = dst_reg;
    desc_ready_o = 1'b0;
    beat_ready_o = 1'b0;
    flit_valid_o = 1'b0;
    flit_last_o  = 1'b0;
    busy_o       = 1'b0;
    case (state_reg)
      IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_valid_i) begin
          dst_next   = desc_dst_id_i;
          cnt_next   = desc_len_i;
          state_next = SEND;
        end
      end
      SEND: begin
        busy_o       = 1'b1;
        flit_valid_o = beat_valid_i;
        beat_ready_o = flit_ready_i;
        flit_last_o  = (cnt_reg == '0);
        if (beat_valid_i && flit_ready_i) begin
          if (cnt_reg == '0) state_next = IDLE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_hs         = flit_valid_o && flit_ready_i;
  assign flit_data_o   = beat_data_i;
  assign flit_dst_id_o = dst_reg;
  assign flit_src_id_o = src_id_i;

  // ---------------- Ejection FIFO ----------------
  localparam int unsigned PtrW   = (EjectFifoDepth > 1) ? $clog2(EjectFifoDepth) : 1;
  localparam int unsigned CntW   = $clog2(EjectFifoDepth + 1);
  localparam int unsigned EntryW = IdWidth + 1 + DataWidth;

  logic [EntryW-1:0] mem [EjectFifoDepth];
  logic [PtrW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]   occ_reg;
  logic              full, empty, push, pop;
  logic [EntryW-1:0] head;

  assign full         = (occ_reg == CntW'(EjectFifoDepth));
  assign empty        = (occ_reg == '0);
  assign flit_ready_o = !full;
  assign rx_valid_o   = !empty;
  assign push         = flit_valid_i && !full;
  assign pop          = !empty && rx_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= {flit_src_id_i, flit_last_i, flit_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(EjectFifoDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(EjectFifoDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push && !pop)      occ_reg <= occ_reg + 1'b1;
      else if (pop && !push) occ_reg <= occ_reg - 1'b1;
    end
  end

  // Head is read combinationally so a pushed flit is visible one cycle later.
  assign head        = mem[rd_ptr_reg];
  assign rx_src_id_o = head[EntryW-1 -: IdWidth];
  assign rx_last_o   = head[DataWidth];
  assign rx_data_o   = head[DataWidth-1:0];

`ifdef FLOO_WIDE_ENDPOINT_STATS_EN
  logic [31:0] tx_cnt_reg, rx_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (tx_hs) tx_cnt_reg <= tx_cnt_reg + 32'd1;
      if (push)  rx_cnt_reg <= rx_cnt_reg + 32'd1;
    end
  end

  assign tx_flits_o = tx_cnt_reg;
  assign rx_flits_o = rx_cnt_reg;
`else
  logic unused_tx_hs;
  assign unused_tx_hs = tx_hs;
`endif

endmodule
